// File: rtl/sr_iter_if.sv
`default_nettype none
// sr_iter_if: start/done handshake and operand/result bus of the iterative right shifter.
// Rev 1.0
interface sr_iter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   in;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         op;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   outp;

  modport master (output start, in, shamt, op, input  busy, done, outp);
  modport slave  (input  start, in, shamt, op, output busy, done, outp);
endinterface
`default_nettype wire

// File: rtl/sr_iter.sv
`default_nettype none
// sr_iter: multi-cycle SRL/SRA right shifter, one binary-weighted stage per clock (MSB first).
// Optional rotate-right on op=10 enabled by macro SR_ITER_ROTATE_EN. Rev 1.0
module sr_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  wire logic clk,
  input  wire logic reset,
  sr_iter_if.slave  bus
);
  localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] shamt_q;
  logic [1:0]         op_q;
  logic               sign_q;
  logic [CNT_W-1:0]   cnt;

  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   srl_val;
  logic [WIDTH-1:0]   fill_mask;
  logic [WIDTH-1:0]   stage_val;
`ifdef SR_ITER_ROTATE_EN
  logic [SHAMT_W-1:0] rot_amt;
`endif

  // One stage of weight 2**cnt; bits vacated at the top are patched per op.
  always_comb begin
    amt       = SHAMT_W'(1) << cnt;
    srl_val   = work >> amt;
    fill_mask = ~({WIDTH{1'b1}} >> amt);
`ifdef SR_ITER_ROTATE_EN
    rot_amt   = SHAMT_W'(0) - amt;
`endif
    stage_val = work;
    if (shamt_q[cnt]) begin
      stage_val = srl_val;
      if (op_q == 2'b01) begin
        stage_val = srl_val | (sign_q ? fill_mask : '0);
      end
`ifdef SR_ITER_ROTATE_EN
      else if (op_q == 2'b10) begin
        stage_val = srl_val | (work << rot_amt);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.outp <= '0;
      work     <= '0;
      shamt_q  <= '0;
      op_q     <= 2'b00;
      sign_q   <= 1'b0;
      cnt      <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            work     <= bus.in;
            shamt_q  <= bus.shamt;
            op_q     <= bus.op;
            sign_q   <= bus.in[WIDTH-1];
            cnt      <= CNT_W'(SHAMT_W - 1);
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            bus.outp <= stage_val;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            work <= stage_val;
            cnt  <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sr_iter.sv
`default_nettype none
// tb_sr_iter: directed, self-checking bench for the iterative right shifter.
// Rev 1.0
module tb_sr_iter;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int LAT     = 5;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sr_iter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  sr_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single edge, then scrambles the inputs so the
  // result only matches if the operands were latched at acceptance.
  task automatic start_op(input logic [31:0] a, input logic [4:0] s, input logic [1:0] o);
    bus.start = 1'b1;
    bus.in    = a;
    bus.shamt = s;
    bus.op    = o;
    tick();
    bus.start = 1'b0;
    bus.in    = ~a;
    bus.shamt = ~s;
    bus.op    = ~o;
  endtask

  task automatic wait_done(input string tag, input int elapsed);
    int n;
    n = elapsed;
    while (bus.done !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(LAT));
    check({tag, " done"}, {31'b0, bus.done}, 32'h1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic [1:0] o,
                        input logic [31:0] exp, input string tag);
    start_op(a, s, o);
    check({tag, " busy"}, {31'b0, bus.busy}, 32'h1);
    wait_done(tag, 0);
    check({tag, " outp"}, bus.outp, exp);
    tick();
    check({tag, " done_width"}, {31'b0, bus.done}, 32'h0);
    check({tag, " held"}, bus.outp, exp);
  endtask

  initial begin
    logic [31:0] rot_exp;
    int          pulses;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.in    = '0;
    bus.shamt = '0;
    bus.op    = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset busy", {31'b0, bus.busy}, 32'h0);
    check("reset done", {31'b0, bus.done}, 32'h0);
    check("reset outp", bus.outp, 32'h0);

    run_op(32'h8000_0000, 5'd16, 2'b00, 32'h0000_8000, "srl16");
    run_op(32'h8000_0000, 5'd16, 2'b01, 32'hFFFF_8000, "sra16");
    run_op(32'h7FFF_FFFF, 5'd31, 2'b01, 32'h0000_0000, "sra31pos");
    run_op(32'hF000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF, "sra31neg");
    run_op(32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, "shamt0");
    run_op(32'h8765_4321, 5'd5,  2'b11, 32'h043B_2A19, "op11srl");

    // Start while busy must be ignored.
    start_op(32'hFFFF_FFFF, 5'd4, 2'b00);
    tick();
    bus.start = 1'b1;
    bus.in    = 32'h0;
    bus.shamt = 5'd1;
    bus.op    = 2'b00;
    tick();
    bus.start = 1'b0;
    wait_done("ignored", 2);
    check("ignored outp", bus.outp, 32'h0FFF_FFFF);

    // Back-to-back start on the done cycle.
    start_op(32'h0000_0010, 5'd4, 2'b00);
    check("b2b busy", {31'b0, bus.busy}, 32'h1);
    tick();
    tick();
    check("b2b outp_hold", bus.outp, 32'h0FFF_FFFF);
    wait_done("b2b", 2);
    check("b2b outp", bus.outp, 32'h0000_0001);
    tick();

    // Reset in the middle of an operation.
    start_op(32'hA5A5_A5A5, 5'd3, 2'b01);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset busy", {31'b0, bus.busy}, 32'h0);
    check("midreset done", {31'b0, bus.done}, 32'h0);
    check("midreset outp", bus.outp, 32'h0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    check("midreset no_done", 32'(pulses), 32'h0);

`ifdef SR_ITER_ROTATE_EN
    rot_exp = 32'h7812_3456;
`else
    rot_exp = 32'h0012_3456;
`endif
    run_op(32'h1234_5678, 5'd8, 2'b10, rot_exp, "op10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/sr_iter.md
Name: sr_iter

Overview:
- Multi-cycle right shifter for the datapath; the opposite direction to the left-shift units.
- Executes SRL/SRA (optionally ROTR) on a 32-bit operand.
- Applies one binary-weighted stage per clock (16, 8, 4, 2, 1).
- Uses a start/done handshake so the control FSM can stall the pipeline while it runs.

Parameters:
- WIDTH, 32, operand/result width; must equal 2**SHAMT_W.
- SHAMT_W, 5, shift-amount width; also the number of stages (cycles).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- in  input  WIDTH  operand, latched when start is accepted.
- shamt  input  SHAMT_W  shift amount, latched with in.
- op  input  2  00 = SRL, 01 = SRA, 10 = ROTR (macro only), 11 = SRL.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse when outp becomes valid.
- outp  output  WIDTH  result; held stable until the next accepted start.

Behaviour:
- Reset (synchronous, reset high at a rising edge):
  - state = IDLE; busy = 0; done = 0; outp = 0; stage counter = 0.
  - Reset overrides everything, including start and any in-flight shift. The partial result is discarded and outp goes to 0.
- States: IDLE, SHIFT.
- IDLE:
  - When start = 1 at edge N: latch in into the working register, latch shamt and op, set stage counter = SHAMT_W-1, go to SHIFT.
  - busy = 1 from edge N.
- SHIFT:
  - At each edge, stage k = counter applies a shift of 2**k when shamt[k] = 1, otherwise passes the value through.
  - Stage order is 16, 8, 4, 2, 1 (MSB first).
  - counter decrements each edge. After stage 0 (edge N+SHAMT_W):
    - outp is loaded from the working value.
    - done = 1 for exactly one cycle; busy = 0; return to IDLE.
- Latency is fixed at SHAMT_W cycles (5) regardless of shamt value. shamt = 0 still takes 5 cycles and returns in unchanged.
- Fill rules:
  - SRL fills vacated MSBs with 0.
  - SRA fills with latched in[WIDTH-1]. The sign is captured at start, not re-read each stage.
- start while busy is ignored: no latch, no effect on the current operation, no queuing.
- start in the same cycle that done is asserted: state is already IDLE, so it is accepted; the next done follows 5 cycles later.
- in, shamt and op may change freely after acceptance without affecting the result.
- outp does not change between done pulses except on reset.
- No arithmetic beyond shifting; no overflow/flag outputs.

Optional Feature:
- Macro SR_ITER_ROTATE_EN.
- When defined: op = 10 performs rotate right. Bits shifted out of the LSB end re-enter at the MSB end at each stage. Latency is unchanged.
- When undefined: op = 10 behaves exactly as SRL (zero fill) and no rotate logic is synthesised.
- Port list is identical in both builds.

Test Plan:
- Reset then idle → busy = 0, done = 0, outp = 0x00000000. Then start, in = 0x80000000, shamt = 16, op = 00 → done exactly 5 cycles after start edge, outp = 0x00008000.
- start, in = 0x80000000, shamt = 16, op = 01 → outp = 0xFFFF8000. start, in = 0x7FFFFFFF, shamt = 31, op = 01 → outp = 0x00000000. start, in = 0xF0000000, shamt = 31, op = 01 → outp = 0xFFFFFFFF.
- start, in = 0x12345678, shamt = 0, op = 00 → 5-cycle latency, outp = 0x12345678; done high for exactly one cycle.
- start with in = 0xFFFFFFFF, shamt = 4, op = 00; re-assert start at cycle 2 with in = 0, shamt = 1 → second request ignored, outp = 0x0FFFFFFF. Back-to-back start on the done cycle with in = 0x00000010, shamt = 4 → accepted, outp = 0x00000001 five cycles later.
- Reset asserted at cycle 3 of an operation → next cycle busy = 0, done = 0, outp = 0; no done pulse follows.
- With SR_ITER_ROTATE_EN: in = 0x12345678, shamt = 8, op = 10 → outp = 0x78123456. Without the macro, same stimulus → outp = 0x00123456.
